// File: rtl/aes_pkg.sv
// Shared AES datapath types and block-geometry helpers.
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;

    typedef logic [BLOCK_W-1:0] aes_block_t;
    typedef logic [31:0]        aes_word_t;

    function automatic int unsigned words_per_block(input int unsigned word_w);
        return (word_w == 0) ? 0 : BLOCK_W / word_w;
    endfunction

    // A legal word width tiles the block exactly with at least two words.
    function automatic bit word_w_ok(input int unsigned word_w);
        if (word_w == 0) return 1'b0;
        return ((BLOCK_W % word_w) == 0) && ((BLOCK_W / word_w) >= 2);
    endfunction

endpackage

// File: rtl/aes_block_packer_if.sv
// Word-in / block-out handshake bundle for the AES block packer.
interface aes_block_packer_if
    import aes_pkg::*;
#(
    parameter int unsigned WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    aes_block_t        out_data;
    logic              partial;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, partial
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, partial
    );
endinterface

// File: rtl/aes_block_packer.sv
// Packs WORD_W-bit words MSB-first into a 128-bit block held for the transpose stage.
module aes_block_packer
    import aes_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    aes_block_packer_if.slave bus
);

    localparam int unsigned WORDS = words_per_block(WORD_W);
    localparam int unsigned CNT_W = (WORDS > 2) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

    if (!word_w_ok(WORD_W)) begin : g_bad_word_w
        $error("aes_block_packer: WORD_W must divide BLOCK_W and give at least two words");
    end

    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_words [WORDS-1];
    aes_block_t        r_out_data;
    logic              r_out_valid;

    logic       w_last;
    logic       w_accept;
    logic       w_complete;
    logic       w_drain;
    aes_block_t w_block;

    assign w_last     = (r_cnt == LAST);
    // Only the completing word can be stalled, and only by an undrained block.
    assign bus.in_ready = !clear && !(w_last && r_out_valid && !bus.out_ready);
    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_complete = w_accept && w_last;
    assign w_drain    = r_out_valid && bus.out_ready;

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.partial   = (r_cnt != '0);

    // Word counter; clear and completion both restart the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || w_complete) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Assembly register for all but the final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < WORDS - 1; k++) begin
                r_words[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < WORDS - 1; k++) begin
                if (w_accept && (r_cnt == CNT_W'(k))) begin
                    r_words[k] <= bus.in_data;
                end
            end
        end
    end

    // Word 0 ends up in the top bits after shifting every word in.
    always_comb begin
        w_block = '0;
        for (int unsigned k = 0; k < WORDS - 1; k++) begin
            w_block = {w_block[BLOCK_W-WORD_W-1:0], r_words[k]};
        end
        w_block = {w_block[BLOCK_W-WORD_W-1:0], bus.in_data};
    end

    // Output register: completion wins over drain so back-to-back blocks never bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_complete) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_block;
        end else if (w_drain) begin
            r_out_valid <= 1'b0;
        end
    end

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (r_out_valid && !bus.out_ready) |=> (r_out_valid && $stable(r_out_data)));

    a_valid_rise: assert property (@(posedge clk) disable iff (!rst_n)
        (!r_out_valid && !w_complete) |=> !r_out_valid);

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed checks of the AES block packer at WORD_W=32 and WORD_W=8.
module tb_aes_block_packer;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic clear_a;
    logic clear_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam aes_block_t PT  = 128'h00112233445566778899aabbccddeeff;
    localparam aes_block_t KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_block_t B8  = 128'h000102030405060708090a0b0c0d0e0f;

    aes_block_t blk [3];

    aes_block_packer_if #(.WORD_W(32)) bus_a ();
    aes_block_packer_if #(.WORD_W(8))  bus_b ();

    aes_block_packer #(.WORD_W(32)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_a),
        .bus   (bus_a)
    );

    aes_block_packer #(.WORD_W(8)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear_b),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic aes_word_t word_of(input aes_block_t b, input int k);
        aes_block_t t;
        t = b << (32 * k);
        return t[127:96];
    endfunction

    task automatic send_a(input aes_word_t w);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = w;
        tick();
    endtask

    initial begin
        blk[0] = 128'h000102030405060708090a0b0c0d0e0f;
        blk[1] = 128'hdeadbeefcafef00d0123456789abcdef;
        blk[2] = KEY;

        rst_n = 1'b0;
        clear_a = 1'b0;
        clear_b = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_out_valid", bus_a.out_valid, 0);
        check("rst_partial", bus_a.partial, 0);
        check("rst_out_data", bus_a.out_data, 0);
        check("rst_out_data_b", bus_b.out_data, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus_a.in_ready, 1);

        // Basic FIPS-197 plaintext packing
        bus_a.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) check("basic_pre_valid", bus_a.out_valid, 0);
            send_a(word_of(PT, k));
        end
        bus_a.in_valid = 1'b0;
        check("basic_valid", bus_a.out_valid, 1);
        check("basic_data", bus_a.out_data, PT);
        check("basic_partial", bus_a.partial, 0);
        tick();
        check("basic_pulse_drop", bus_a.out_valid, 0);
        check("basic_data_hold", bus_a.out_data, PT);

        // Throughput: three blocks back to back
        for (int i = 0; i < 12; i++) begin
            bus_a.in_valid = 1'b1;
            bus_a.in_data  = word_of(blk[i/4], i % 4);
            #1;
            check($sformatf("thr_in_ready_%0d", i), bus_a.in_ready, 1);
            tick();
            check($sformatf("thr_valid_%0d", i), bus_a.out_valid, ((i % 4) == 3) ? 1 : 0);
            if ((i % 4) == 3) check($sformatf("thr_data_%0d", i), bus_a.out_data, blk[i/4]);
        end
        bus_a.in_valid = 1'b0;
        tick();
        check("thr_end_valid", bus_a.out_valid, 0);

        // Backpressure: block held, final word of next block stalls
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send_a(word_of((i < 4) ? PT : KEY, i % 4));
        bus_a.in_data = word_of(KEY, 3);
        #1;
        check("bp_held_valid", bus_a.out_valid, 1);
        check("bp_held_data", bus_a.out_data, PT);
        check("bp_in_ready_low", bus_a.in_ready, 0);
        tick();
        check("bp_stable_data", bus_a.out_data, PT);
        check("bp_in_ready_wait", bus_a.in_ready, 0);
        check("bp_partial", bus_a.partial, 1);
        bus_a.out_ready = 1'b1;
        #1;
        check("bp_in_ready_drain", bus_a.in_ready, 1);
        tick();
        bus_a.out_ready = 1'b0;
        bus_a.in_valid  = 1'b0;
        check("bp_next_valid", bus_a.out_valid, 1);
        check("bp_next_data", bus_a.out_data, KEY);
        check("bp_next_partial", bus_a.partial, 0);
        bus_a.out_ready = 1'b1;
        tick();
        check("bp_drained", bus_a.out_valid, 0);

        // Clear discards a partial block
        send_a(32'h11111111);
        send_a(32'h22222222);
        check("clr_partial_pre", bus_a.partial, 1);
        clear_a = 1'b1;
        bus_a.in_data = 32'h33333333;
        #1;
        check("clr_in_ready", bus_a.in_ready, 0);
        tick();
        clear_a = 1'b0;
        check("clr_partial_post", bus_a.partial, 0);
        check("clr_no_valid", bus_a.out_valid, 0);
        for (int k = 0; k < 4; k++) send_a(word_of(blk[0], k));
        bus_a.in_valid = 1'b0;
        check("clr_block_valid", bus_a.out_valid, 1);
        check("clr_block_data", bus_a.out_data, blk[0]);
        tick();

        // Asynchronous reset with cnt == 3 and a block held
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send_a(word_of((i < 4) ? PT : KEY, i % 4));
        bus_a.in_valid = 1'b0;
        check("arst_pre_valid", bus_a.out_valid, 1);
        check("arst_pre_partial", bus_a.partial, 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", bus_a.out_valid, 0);
        check("arst_partial", bus_a.partial, 0);
        check("arst_data", bus_a.out_data, 0);
        tick();
        rst_n = 1'b1;
        bus_a.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) send_a(word_of(blk[1], k));
        bus_a.in_valid = 1'b0;
        check("arst_fresh_valid", bus_a.out_valid, 1);
        check("arst_fresh_data", bus_a.out_data, blk[1]);
        tick();

        // Byte-wide variant
        bus_b.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus_b.in_valid = 1'b1;
            bus_b.in_data  = 8'(i);
            #1;
            check($sformatf("b8_in_ready_%0d", i), bus_b.in_ready, 1);
            tick();
            if (i == 14) check("b8_pre_valid", bus_b.out_valid, 0);
        end
        bus_b.in_valid = 1'b0;
        check("b8_valid", bus_b.out_valid, 1);
        check("b8_data", bus_b.out_data, B8);
        tick();
        check("b8_drop", bus_b.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
